mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-port arbiter and sequencer for the single shared 16-bit memory bus.
- Port 0 is the CPU (read/write/address/mem_out/mem_in). Port 1 is a secondary master, such as a program loader or DMA engine driving the memory bus.
- Serialises accesses, holds address, data and strobes stable for a fixed memory latency, and returns a one-cycle ack plus latched read data to the winning requester.

Parameters:
- AW, 16, address width.
- DW, 16, data width.
- WAIT_CYC, 2, cycles mem_read/mem_write stay asserted per access (legal range 1..15; 0 is illegal and must trigger a simulation $error).

Ports:
- clk  input  1  system clock, rising edge.
- rst_b  input  1  asynchronous active-low reset.
- m0_req  input  1  port 0 (CPU) access request; held high until m0_ack.
- m0_we  input  1  port 0: 1 = write, 0 = read.
- m0_addr  input  AW  port 0 address.
- m0_wdata  input  DW  port 0 write data.
- m0_rdata  output  DW  port 0 read data, registered.
- m0_ack  output  1  port 0 completion, one-cycle pulse.
- m1_req  input  1  port 1 access request.
- m1_we  input  1  port 1 write enable.
- m1_addr  input  AW  port 1 address.
- m1_wdata  input  DW  port 1 write data.
- m1_rdata  output  DW  port 1 read data, registered.
- m1_ack  output  1  port 1 completion pulse.
- mem_addr  output  AW  memory address.
- mem_wdata  output  DW  memory write data.
- mem_rdata  input  DW  memory read data.
- mem_read  output  1  memory read strobe.
- mem_write  output  1  memory write strobe.
- busy  output  1  high whenever state is not IDLE.
- owner  output  1  port currently or last granted (0/1).

Behaviour:
- Reset (rst_b low, asynchronous): state = IDLE, counter = 0.
  - All outputs reset to 0: mem_addr, mem_wdata, mem_read, mem_write, m0/m1_rdata, m0/m1_ack, busy, owner.
  - Reset asserted mid-access aborts the access: strobes drop immediately and no ack is issued.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - No request: stay in IDLE.
  - Any request: at the clock edge, latch the winner's addr, wdata and we into mem_addr, mem_wdata and an internal we; set owner; load counter = WAIT_CYC-1; go to ACCESS.
- ACCESS:
  - mem_read = ~we and mem_write = we, asserted for exactly WAIT_CYC cycles.
  - mem_addr and mem_wdata are held constant throughout.
  - When counter == 0: on a read, register mem_rdata into the owner's rdata; go to RESP. Otherwise decrement counter.
- RESP:
  - Owner's ack = 1 for exactly one cycle; strobes are low.
  - Next state is IDLE unconditionally, so there is always one idle/arbitration cycle between accesses.
- Latency: request sampled in IDLE at cycle N → strobes in cycles N+1..N+WAIT_CYC → ack in cycle N+WAIT_CYC+1.
- Requester handshake: drop req (or present a new transaction) on the edge where ack is sampled high. A req still high in the next IDLE cycle is a new access.
- Req deasserted during ACCESS: not an abort; the access completes and ack still pulses.
- Requester inputs are ignored outside IDLE.
- Writes never modify rdata. Each rdata holds its value until the next read completed by that port.
- Arbitration when both ports request in IDLE: fixed priority, port 0 wins (port 1 may starve; this is accepted).
- Never both acks high at once; never mem_read and mem_write high together.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin on simultaneous requests. The port not equal to the last owner wins. The last owner is the owner register, which resets to 0, so port 1 wins the first tie after reset.
- Undefined: fixed priority, port 0 wins every tie.
- Single-requester behaviour is identical in both builds.

Test Plan:
- Reset: assert rst_b=0 with random inputs → all outputs 0, busy=0; after release, no strobes until a req is seen.
- Port 0 read (WAIT_CYC=2), m0_req at cycle 0, m0_addr=0x0010, mem_rdata=0xBEEF → mem_read high cycles 1-2 with mem_addr=0x0010, m0_ack in cycle 3, m0_rdata=0xBEEF afterwards, m1_ack stays 0.
- Port 1 write, m1_addr=0x0200, m1_wdata=0x1234 → mem_write high 2 cycles with addr and data stable, m1_ack one cycle, m1_rdata unchanged, owner=1.
- Both ports hold req for 4 transactions → fixed build grants 0,0,0,0; MEM_ARB_RR_EN build grants 1,0,1,0. Each access is separated by exactly one IDLE cycle.
- rst_b pulsed low during cycle 1 of a port 0 ACCESS → mem_read falls asynchronously, no m0_ack; after release, state is IDLE and busy=0.
- m0_req dropped after one ACCESS cycle of a read of 0x0042 (mem_rdata=0x00AA) → access still completes, m0_ack pulses, m0_rdata=0x00AA.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester ports and shared memory bus for mem_arbiter.
// slave = arbiter side, master = requesters plus memory model.
interface mem_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          m0_req;
  logic          m0_we;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic [DW-1:0] m0_rdata;
  logic          m0_ack;

  logic          m1_req;
  logic          m1_we;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic [DW-1:0] m1_rdata;
  logic          m1_ack;

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_read;
  logic          mem_write;

  logic          busy;
  logic          owner;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_rdata, m0_ack,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m1_rdata, m1_ack,
    output mem_addr, mem_wdata, mem_read, mem_write,
    input  mem_rdata,
    output busy, owner
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_rdata, m0_ack,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m1_rdata, m1_ack,
    input  mem_addr, mem_wdata, mem_read, mem_write,
    output mem_rdata,
    input  busy, owner
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port sequencer for the shared memory bus.
// Define MEM_ARB_RR_EN for round-robin ties; default is port 0 priority.
module mem_arbiter #(
  parameter int AW       = 16,
  parameter int DW       = 16,
  parameter int WAIT_CYC = 2
) (
  input logic        clk,
  input logic        rst_b,
  mem_arbiter_if.slave bus
);

  if (WAIT_CYC < 1 || WAIT_CYC > 15) begin : g_bad_wait
    $error("mem_arbiter: WAIT_CYC must be 1..15");
  end

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t        state;
  logic [3:0]    cnt;
  logic          we_q;
  logic          own_q;
  logic          busy_q;
  logic          rd_q;
  logic          wr_q;
  logic          ack0_q;
  logic          ack1_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata0_q;
  logic [DW-1:0] rdata1_q;

  logic          any_req;
  logic          pick;
  logic          win_we;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_wdata;

  // Pick the winner among requests sampled in IDLE.
  always_comb begin
    any_req = bus.m0_req | bus.m1_req;
`ifdef MEM_ARB_RR_EN
    pick = (bus.m0_req & bus.m1_req) ? ~own_q : ~bus.m0_req;
`else
    pick = ~bus.m0_req;
`endif
    win_we    = pick ? bus.m1_we    : bus.m0_we;
    win_addr  = pick ? bus.m1_addr  : bus.m0_addr;
    win_wdata = pick ? bus.m1_wdata : bus.m0_wdata;
  end

  // Access sequencer with registered bus, ack and read-data outputs.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state    <= IDLE;
      cnt      <= '0;
      we_q     <= 1'b0;
      own_q    <= 1'b0;
      busy_q   <= 1'b0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          ack0_q <= 1'b0;
          ack1_q <= 1'b0;
          if (any_req) begin
            addr_q  <= win_addr;
            wdata_q <= win_wdata;
            we_q    <= win_we;
            own_q   <= pick;
            cnt     <= CNT_INIT;
            rd_q    <= ~win_we;
            wr_q    <= win_we;
            busy_q  <= 1'b1;
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            rd_q  <= 1'b0;
            wr_q  <= 1'b0;
            state <= RESP;
            unique case (1'b1)
              own_q: begin
                ack1_q <= 1'b1;
                if (!we_q) rdata1_q <= bus.mem_rdata;
              end
              default: begin
                ack0_q <= 1'b1;
                if (!we_q) rdata0_q <= bus.mem_rdata;
              end
            endcase
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          ack0_q <= 1'b0;
          ack1_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_read  = rd_q;
  assign bus.mem_write = wr_q;
  assign bus.m0_ack    = ack0_q;
  assign bus.m1_ack    = ack1_q;
  assign bus.m0_rdata  = rdata0_q;
  assign bus.m1_rdata  = rdata1_q;
  assign bus.busy      = busy_q;
  assign bus.owner     = own_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector table plus arbitration,
// mid-access reset and dropped-request sequences.
module tb_mem_arbiter;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int WC = 2;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_arbiter #(.AW(AW), .DW(DW), .WAIT_CYC(WC)) dut (
    .clk(clk),
    .rst_b(rst_b),
    .bus(bus)
  );

  typedef struct {
    logic        r0;
    logic        w0;
    logic [15:0] a0;
    logic [15:0] d0;
    logic        r1;
    logic        w1;
    logic [15:0] a1;
    logic [15:0] d1;
    logic [15:0] mrd;
    logic [69:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [69:0] mk(
    logic rd, logic wr, logic [15:0] ad, logic [15:0] wd,
    logic k0, logic k1, logic bz, logic ow,
    logic [15:0] q0, logic [15:0] q1);
    return {rd, wr, ad, wd, k0, k1, bz, ow, q0, q1};
  endfunction

  function automatic logic [69:0] snap();
    return {bus.mem_read, bus.mem_write, bus.mem_addr,
            bus.mem_wdata, bus.m0_ack, bus.m1_ack,
            bus.busy, bus.owner, bus.m0_rdata, bus.m1_rdata};
  endfunction

  task automatic chk(string nm, logic [69:0] e);
    logic [69:0] g;
    g = snap();
    n_cmp++;
    if (g !== e) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, g, e);
    end
  endtask

  task automatic add(
    logic r0, logic w0, logic [15:0] a0, logic [15:0] d0,
    logic r1, logic w1, logic [15:0] a1, logic [15:0] d1,
    logic [15:0] mrd, logic [69:0] e);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.mrd = mrd; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic drive(vec_t v);
    bus.m0_req   = v.r0;
    bus.m0_we    = v.w0;
    bus.m0_addr  = v.a0;
    bus.m0_wdata = v.d0;
    bus.m1_req   = v.r1;
    bus.m1_we    = v.w1;
    bus.m1_addr  = v.a1;
    bus.m1_wdata = v.d1;
    bus.mem_rdata = v.mrd;
  endtask

  task automatic idle_in();
    bus.m0_req = 1'b0; bus.m0_we = 1'b0;
    bus.m0_addr = '0; bus.m0_wdata = '0;
    bus.m1_req = 1'b0; bus.m1_we = 1'b0;
    bus.m1_addr = '0; bus.m1_wdata = '0;
    bus.mem_rdata = '0;
  endtask

  initial begin
    int exp_g[4];
    int last_c;
    int cyc;
    logic [69:0] z;
    z = '0;
`ifdef MEM_ARB_RR_EN
    exp_g = '{1, 0, 1, 0};
`else
    exp_g = '{0, 0, 0, 0};
`endif

    // port 0 read of 0x0010 -> 0xBEEF
    add(1,0,16'h0010,0, 0,0,0,0, 16'hBEEF,
        mk(0,0,16'h0000,0, 0,0,0,0, 0,0));
    add(1,0,16'h0010,0, 0,0,0,0, 16'hBEEF,
        mk(1,0,16'h0010,0, 0,0,1,0, 0,0));
    add(1,0,16'h0010,0, 0,0,0,0, 16'hBEEF,
        mk(1,0,16'h0010,0, 0,0,1,0, 0,0));
    add(0,0,16'h0010,0, 0,0,0,0, 16'hBEEF,
        mk(0,0,16'h0010,0, 1,0,1,0, 16'hBEEF,0));
    // port 1 write 0x1234 -> 0x0200
    add(0,0,0,0, 1,1,16'h0200,16'h1234, 16'hFFFF,
        mk(0,0,16'h0010,0, 0,0,0,0, 16'hBEEF,0));
    add(0,0,0,0, 1,1,16'h0200,16'h1234, 16'hFFFF,
        mk(0,1,16'h0200,16'h1234, 0,0,1,1, 16'hBEEF,0));
    add(0,0,0,0, 1,1,16'h0200,16'h1234, 16'hFFFF,
        mk(0,1,16'h0200,16'h1234, 0,0,1,1, 16'hBEEF,0));
    add(0,0,0,0, 0,1,16'h0200,16'h1234, 16'hFFFF,
        mk(0,0,16'h0200,16'h1234, 0,1,1,1, 16'hBEEF,0));
    add(0,0,0,0, 0,0,0,0, 16'hFFFF,
        mk(0,0,16'h0200,16'h1234, 0,0,0,1, 16'hBEEF,0));
    // port 0 read 0x0042, req dropped after first strobe cycle
    add(1,0,16'h0042,0, 0,0,0,0, 16'h00AA,
        mk(0,0,16'h0200,16'h1234, 0,0,0,1, 16'hBEEF,0));
    add(1,0,16'h0042,0, 0,0,0,0, 16'h00AA,
        mk(1,0,16'h0042,0, 0,0,1,0, 16'hBEEF,0));
    add(0,0,16'h0042,0, 0,0,0,0, 16'h00AA,
        mk(1,0,16'h0042,0, 0,0,1,0, 16'hBEEF,0));
    add(0,0,16'h0042,0, 0,0,0,0, 16'h00AA,
        mk(0,0,16'h0042,0, 1,0,1,0, 16'h00AA,0));
    // port 1 read 0x0300 -> 0xC0DE
    add(0,0,0,0, 1,0,16'h0300,16'h5555, 16'hC0DE,
        mk(0,0,16'h0042,0, 0,0,0,0, 16'h00AA,0));
    add(0,0,0,0, 1,0,16'h0300,16'h5555, 16'hC0DE,
        mk(1,0,16'h0300,16'h5555, 0,0,1,1, 16'h00AA,0));
    add(0,0,0,0, 1,0,16'h0300,16'h5555, 16'hC0DE,
        mk(1,0,16'h0300,16'h5555, 0,0,1,1, 16'h00AA,0));
    add(0,0,0,0, 0,0,16'h0300,16'h5555, 16'hC0DE,
        mk(0,0,16'h0300,16'h5555, 0,1,1,1, 16'h00AA,16'hC0DE));
    add(0,0,0,0, 0,0,0,0, 16'hC0DE,
        mk(0,0,16'h0300,16'h5555, 0,0,0,1, 16'h00AA,16'hC0DE));

    // reset with random inputs
    rst_b = 1'b0;
    bus.m0_req = 1'($urandom); bus.m0_we = 1'($urandom);
    bus.m0_addr = 16'($urandom); bus.m0_wdata = 16'($urandom);
    bus.m1_req = 1'b1; bus.m1_we = 1'($urandom);
    bus.m1_addr = 16'($urandom); bus.m1_wdata = 16'($urandom);
    bus.mem_rdata = 16'($urandom);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", z);
    idle_in();
    @(posedge clk); #1;
    rst_b = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk($sformatf("post_reset_idle%0d", i), z);
      @(posedge clk); #1;
    end

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      @(negedge clk);
      chk($sformatf("vec%0d", i), vecs[i].exp);
      @(posedge clk); #1;
    end

    // both ports request continuously from a fresh reset
    idle_in();
    rst_b = 1'b0;
    @(posedge clk); #1;
    rst_b = 1'b1;
    bus.m0_req = 1'b1; bus.m0_addr = 16'h0100;
    bus.m1_req = 1'b1; bus.m1_addr = 16'h0101;
    cyc = 0;
    last_c = 0;
    for (int k = 0; k < 4; k++) begin
      int t;
      logic got;
      t = 0;
      got = 1'b0;
      while (!got && t < 20) begin
        @(negedge clk);
        cyc++;
        t++;
        if (bus.m0_ack | bus.m1_ack) got = 1'b1;
      end
      n_cmp++;
      if (!got) begin
        n_bad++;
        $display("FAIL arb_timeout%0d: no ack in 20 cycles", k);
      end else begin
        logic [1:0] ga;
        logic [1:0] ge;
        ga = {bus.m1_ack, bus.m0_ack};
        ge = (exp_g[k] == 1) ? 2'b10 : 2'b01;
        if (ga !== ge) begin
          n_bad++;
          $display("FAIL arb_grant%0d: acks %b want %b", k, ga, ge);
        end
        if (k > 0) begin
          n_cmp++;
          if (cyc - last_c != WC + 2) begin
            n_bad++;
            $display("FAIL arb_gap%0d: got %0d want %0d",
                     k, cyc - last_c, WC + 2);
          end
        end
        last_c = cyc;
      end
    end
    idle_in();
    repeat (3) @(posedge clk);
    #1;

    // reset pulse in the first strobe cycle of a port 0 read
    bus.m0_req = 1'b1; bus.m0_addr = 16'h0077;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if (bus.mem_read !== 1'b1 || bus.busy !== 1'b1) begin
      n_bad++;
      $display("FAIL abort_pre: rd=%b busy=%b want 1 1",
               bus.mem_read, bus.busy);
    end
    #1 rst_b = 1'b0;
    bus.m0_req = 1'b0;
    #1 chk("abort_async", z);
    #1 rst_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("abort_after%0d", i), z);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
